// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the raster timing generator: the default XGA
// (1024x768 from a 64 MHz clock) porch/sync widths, the derived line and
// frame totals, and the counter widths used by vga_timing_gen and
// vga_axis_counter.
// Also provides a small helper that turns a sync-window flag into the
// configured sync output level.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  // Vertical timing, in lines
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  // Counter and output widths
  localparam int H_CNT_W     = 11;
  localparam int V_CNT_W     = 10;
  localparam int PIX_W       = 10;
  localparam int FRAME_CNT_W = 8;

  // Sync outputs sit at 'polarity' inside the sync window and at the
  // opposite level everywhere else.
  function automatic logic sync_level(input logic in_window, input logic polarity);
    return in_window ? polarity : ~polarity;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each
// 'advance' cycle and decodes the region flags from the current count.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset, clears the count
//   advance      in   step the count this cycle
//   wrap         out  advance is high and the count is at TOTAL-1, so the
//                     count returns to 0 on this edge
//   active       out  count < ACTIVE
//   sync_window  out  count in [ACTIVE+FP, ACTIVE+FP+SYNC)
//   count        out  current count
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = XGA_H_ACTIVE,
  parameter int FP     = XGA_H_FP,
  parameter int SYNC   = XGA_H_SYNC,
  parameter int BP     = XGA_H_BP,
  parameter int W      = H_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  output logic         wrap,
  output logic         active,
  output logic         sync_window,
  output logic [W-1:0] count
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;

  localparam logic [W-1:0] LAST_COUNT = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO    = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_HI    = W'(SYNC_END);

  logic at_last;

  assign at_last     = (count == LAST_COUNT);
  // wrap already includes 'advance' so the next axis can use it directly
  // as its own advance enable.
  assign wrap        = advance && at_last;
  assign active      = (count < ACTIVE_END);
  assign sync_window = (count >= SYNC_LO) && (count < SYNC_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (advance) begin
      count <= at_last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator for the TinyQV video peripheral. Produces
// registered hsync/vsync, the active-area flag and coordinates, line and
// frame strobes, a wrapping completed-frame counter and an optional
// scan-line interrupt. All outputs are one cycle behind the raster
// counters and only update on pix_ce cycles.
//
// Build option:
//   VGA_TIMING_LINE_IRQ_EN  when defined, line_irq pulses on the output
//                           cycle for column H_ACTIVE of line line_cmp.
//                           When undefined, line_irq is tied low and
//                           line_cmp is ignored.
//
// Ports:
//   clk          in   project clock
//   reset        in   synchronous active-high reset
//   pix_ce       in   pixel advance enable; everything holds when low
//   polarity     in   sync active level (1 = positive, 0 = negative)
//   line_cmp     in   scan line that raises line_irq
//   hsync        out  horizontal sync
//   vsync        out  vertical sync
//   visible      out  active-area flag
//   pix_x        out  active-area column (0 outside the active area)
//   pix_y        out  active-area row (0 outside the active area)
//   frame_start  out  one-cycle pulse at the first pixel of a frame
//   line_start   out  one-cycle pulse at the first pixel of each line
//   frame_count  out  completed-frame counter, wraps at 256
//   line_irq     out  one-cycle scan-line interrupt pulse
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_ce,
  input  logic                   polarity,
  input  logic [V_CNT_W-1:0]     line_cmp,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   visible,
  output logic [PIX_W-1:0]       pix_x,
  output logic [PIX_W-1:0]       pix_y,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   line_irq
);

  logic [H_CNT_W-1:0]     h_cnt;
  logic [V_CNT_W-1:0]     v_cnt;
  logic                   h_wrap;
  logic                   h_active;
  logic                   h_sync_window;
  logic                   v_wrap;
  logic                   v_active;
  logic                   v_sync_window;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (H_CNT_W)
  ) u_h_axis (
    .clk         (clk),
    .reset       (reset),
    .advance     (pix_ce),
    .wrap        (h_wrap),
    .active      (h_active),
    .sync_window (h_sync_window),
    .count       (h_cnt)
  );

  // The vertical axis steps once per line, on the same edge the
  // horizontal count returns to 0. Its wrap therefore marks the
  // last pixel of the frame.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (V_CNT_W)
  ) u_v_axis (
    .clk         (clk),
    .reset       (reset),
    .advance     (h_wrap),
    .wrap        (v_wrap),
    .active      (v_active),
    .sync_window (v_sync_window),
    .count       (v_cnt)
  );

  // Internal frame counter steps with the counter wrap; the output copy is
  // registered with the other outputs so frame_count changes on the same
  // output cycle as frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  // Output register: decode of the current counters, one cycle late.
  // Level outputs hold while pix_ce is low; the strobes are cleared so a
  // stalled pixel never produces a repeated pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~polarity;
      vsync       <= ~polarity;
      visible     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      frame_count <= '0;
    end else if (pix_ce) begin
      hsync       <= sync_level(h_sync_window, polarity);
      vsync       <= sync_level(v_sync_window, polarity);
      visible     <= h_active && v_active;
      pix_x       <= h_active ? h_cnt[PIX_W-1:0] : '0;
      pix_y       <= v_active ? v_cnt : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      line_start  <= (h_cnt == '0);
      frame_count <= frame_cnt;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  localparam logic [H_CNT_W-1:0] IRQ_COLUMN = H_CNT_W'(H_ACTIVE);

  // Fires with the output where visible falls on line line_cmp. A
  // line_cmp beyond the last line never matches because v_cnt never
  // reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_irq <= 1'b0;
    end else begin
      line_irq <= pix_ce && (h_cnt == IRQ_COLUMN) && (v_cnt == line_cmp);
    end
  end
`else
  logic unused_line_cmp;

  assign unused_line_cmp = ^line_cmp;
  assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. A reduced-timing instance
// (16 x 8 raster) exercises whole frames, pix_ce gating, polarity, the
// scan-line interrupt, mid-frame reset and frame_count wrap; a default
// XGA instance checks the first line against the real constants.
// Expected outputs come from a reference model driven by the linear pixel
// index and are queued per cycle, then popped after the clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       frame_start;
    logic       line_start;
    logic [7:0] frame_count;
    logic       line_irq;
  } obs_t;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
  } tim_t;

`ifdef VGA_TIMING_LINE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam int S_HA = 10, S_HFP = 1, S_HS = 3, S_HBP = 2;
  localparam int S_VA = 4,  S_VFP = 1, S_VS = 2, S_VBP = 1;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
  localparam int S_FRAME = S_HT * S_VT;
  localparam tim_t SMALL = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP};
  localparam tim_t XGA   = '{1024, 24, 136, 160, 768, 3, 6, 29};
  localparam int X_FRAME = 1344 * 806;

  logic       clk;
  logic       reset;
  logic       pix_ce;
  logic       polarity;
  logic [9:0] line_cmp;

  logic       s_hsync, s_vsync, s_visible, s_frame_start, s_line_start, s_line_irq;
  logic [9:0] s_pix_x, s_pix_y;
  logic [7:0] s_frame_count;
  logic       x_hsync, x_vsync, x_visible, x_frame_start, x_line_start, x_line_irq;
  logic [9:0] x_pix_x, x_pix_y;
  logic [7:0] x_frame_count;

  obs_t s_obs;
  obs_t x_obs;

  int tests_run = 0;
  int tests_failed = 0;

  obs_t s_q[$];
  obs_t x_q[$];
  int   s_idx = 0, s_frames = 0;
  int   x_idx = 0, x_frames = 0;
  obs_t s_last;
  obs_t x_last;

  assign s_obs = {s_hsync, s_vsync, s_visible, s_pix_x, s_pix_y,
                  s_frame_start, s_line_start, s_frame_count, s_line_irq};
  assign x_obs = {x_hsync, x_vsync, x_visible, x_pix_x, x_pix_y,
                  x_frame_start, x_line_start, x_frame_count, x_line_irq};

  vga_timing_gen #(
    .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP)
  ) dut_small (
    .clk (clk), .reset (reset), .pix_ce (pix_ce), .polarity (polarity),
    .line_cmp (line_cmp), .hsync (s_hsync), .vsync (s_vsync),
    .visible (s_visible), .pix_x (s_pix_x), .pix_y (s_pix_y),
    .frame_start (s_frame_start), .line_start (s_line_start),
    .frame_count (s_frame_count), .line_irq (s_line_irq)
  );

  vga_timing_gen dut_xga (
    .clk (clk), .reset (reset), .pix_ce (pix_ce), .polarity (polarity),
    .line_cmp (line_cmp), .hsync (x_hsync), .vsync (x_vsync),
    .visible (x_visible), .pix_x (x_pix_x), .pix_y (x_pix_y),
    .frame_start (x_frame_start), .line_start (x_line_start),
    .frame_count (x_frame_count), .line_irq (x_line_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference output for the raster position 'idx' (pixels since frame start).
  function automatic obs_t model_out(input tim_t t, input int idx, input int frames,
                                     input logic pol, input int cmp);
    obs_t o;
    int ht, h, v;
    ht = t.ha + t.hfp + t.hs + t.hbp;
    h  = idx % ht;
    v  = idx / ht;
    o  = '0;
    o.visible     = (h < t.ha) && (v < t.va);
    o.hsync       = ((h >= t.ha + t.hfp) && (h < t.ha + t.hfp + t.hs)) ? pol : ~pol;
    o.vsync       = ((v >= t.va + t.vfp) && (v < t.va + t.vfp + t.vs)) ? pol : ~pol;
    o.pix_x       = (h < t.ha) ? 10'(h) : 10'd0;
    o.pix_y       = (v < t.va) ? 10'(v) : 10'd0;
    o.line_start  = (h == 0);
    o.frame_start = (idx == 0);
    o.frame_count = 8'(frames);
    o.line_irq    = IRQ_EN && (h == t.ha) && (v == cmp);
    return o;
  endfunction

  function automatic obs_t reset_out(input logic pol);
    obs_t o;
    o = '0;
    o.hsync = ~pol;
    o.vsync = ~pol;
    return o;
  endfunction

  // Queue the expected small-instance output for the inputs now driven,
  // then clock once and settle.
  task automatic cycle_small();
    obs_t e;
    if (reset) begin
      e = reset_out(polarity);
      s_idx = 0;
      s_frames = 0;
    end else if (pix_ce) begin
      e = model_out(SMALL, s_idx, s_frames, polarity, int'(line_cmp));
      s_idx++;
      if (s_idx == S_FRAME) begin
        s_idx = 0;
        s_frames++;
      end
    end else begin
      e = s_last;
      e.frame_start = 1'b0;
      e.line_start = 1'b0;
      e.line_irq = 1'b0;
    end
    s_last = e;
    s_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_xga();
    obs_t e;
    if (reset) begin
      e = reset_out(polarity);
      x_idx = 0;
      x_frames = 0;
    end else if (pix_ce) begin
      e = model_out(XGA, x_idx, x_frames, polarity, int'(line_cmp));
      x_idx++;
      if (x_idx == X_FRAME) begin
        x_idx = 0;
        x_frames++;
      end
    end else begin
      e = x_last;
      e.frame_start = 1'b0;
      e.line_start = 1'b0;
      e.line_irq = 1'b0;
    end
    x_last = e;
    x_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    reset = 1'b1; pix_ce = 1'b1; polarity = 1'b1; line_cmp = 10'd1023;
    for (int i = 0; i < 3; i++) begin
      cycle_small();
      got = s_obs; exp = s_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL reset_values: got %h expected %h", got, exp);
      end
    end
    polarity = 1'b0;
    cycle_small();
    got = s_obs; exp = s_q.pop_front(); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL reset_pol0: got %h expected %h", got, exp);
    end
    tests_run++;
    if ({got.hsync, got.vsync} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL reset_sync_idle: got %b expected 11", {got.hsync, got.vsync});
    end
    polarity = 1'b1;
    cycle_small();
    got = s_obs; exp = s_q.pop_front(); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL reset_pol1: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_first_frame();
    obs_t got, exp;
    int vs_cycles = 0, vs_first = -1, fs_gap = -1;
    logic [7:0] fc_second = 8'hxx;
    reset = 1'b0; pix_ce = 1'b1; polarity = 1'b1;
    for (int c = 1; c <= S_FRAME + 2; c++) begin
      cycle_small();
      got = s_obs; exp = s_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL first_frame c=%0d: got %h expected %h", c, got, exp);
      end
      if (c == 1) begin
        tests_run++;
        if ({got.frame_start, got.line_start, got.visible, got.pix_x, got.pix_y} !== {3'b111, 20'd0}) begin
          tests_failed++;
          $display("[TB] FAIL first_pixel: got fs=%b ls=%b vis=%b x=%0d y=%0d expected 1 1 1 0 0",
                   got.frame_start, got.line_start, got.visible, got.pix_x, got.pix_y);
        end
      end
      if (c <= S_FRAME && got.vsync) begin
        vs_cycles++;
        if (vs_first < 0) vs_first = c;
      end
      if (got.frame_start && c > 1 && fs_gap < 0) begin
        fs_gap = c - 1;
        fc_second = got.frame_count;
      end
    end
    tests_run++;
    if (vs_cycles != S_VS * S_HT) begin
      tests_failed++;
      $display("[TB] FAIL vsync_width: got %0d expected %0d", vs_cycles, S_VS * S_HT);
    end
    tests_run++;
    if (vs_first != (S_VA + S_VFP) * S_HT + 1) begin
      tests_failed++;
      $display("[TB] FAIL vsync_start: got %0d expected %0d", vs_first, (S_VA + S_VFP) * S_HT + 1);
    end
    tests_run++;
    if (fs_gap != S_FRAME) begin
      tests_failed++;
      $display("[TB] FAIL frame_length: got %0d expected %0d", fs_gap, S_FRAME);
    end
    tests_run++;
    if (fc_second !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL frame_count_one: got %0d expected 1", fc_second);
    end
  endtask

  task automatic test_pix_ce_gating();
    obs_t got, exp;
    int ce_since = 0, measured = -1;
    bit started = 1'b0;
    for (int c = 0; c < 800; c++) begin
      pix_ce = ($urandom_range(0, 3) != 0);
      cycle_small();
      got = s_obs; exp = s_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL ce_gating c=%0d ce=%b: got %h expected %h", c, pix_ce, got, exp);
      end
      if (!pix_ce) begin
        tests_run++;
        if ({got.frame_start, got.line_start, got.line_irq} !== 3'b000) begin
          tests_failed++;
          $display("[TB] FAIL ce_low_pulses: got %b expected 000",
                   {got.frame_start, got.line_start, got.line_irq});
        end
      end else begin
        if (got.frame_start) begin
          if (started && measured < 0) measured = ce_since;
          started = 1'b1;
          ce_since = 0;
        end
        ce_since++;
      end
    end
    tests_run++;
    if (measured != S_FRAME) begin
      tests_failed++;
      $display("[TB] FAIL ce_frame_length: got %0d expected %0d", measured, S_FRAME);
    end
    pix_ce = 1'b1;
  endtask

  task automatic test_line_irq();
    obs_t got, exp;
    int cmps[3] = '{2, 900, S_VA + 1};
    int pulses;
    reset = 1'b1; pix_ce = 1'b1; polarity = 1'b1;
    cycle_small();
    void'(s_q.pop_front());
    reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      line_cmp = 10'(cmps[p]);
      pulses = 0;
      for (int c = 0; c < S_FRAME; c++) begin
        cycle_small();
        got = s_obs; exp = s_q.pop_front(); tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("[TB] FAIL line_irq_frame cmp=%0d: got %h expected %h", cmps[p], got, exp);
        end
        if (got.line_irq) begin
          pulses++;
          if (cmps[p] < S_VA) begin
            tests_run++;
            if ({got.visible, got.pix_y} !== {1'b0, 10'(cmps[p])}) begin
              tests_failed++;
              $display("[TB] FAIL line_irq_position: got vis=%b y=%0d expected vis=0 y=%0d",
                       got.visible, got.pix_y, cmps[p]);
            end
          end
        end
      end
      tests_run++;
      if (pulses != ((cmps[p] < S_VT) ? int'(IRQ_EN) : 0)) begin
        tests_failed++;
        $display("[TB] FAIL line_irq_count cmp=%0d: got %0d expected %0d", cmps[p], pulses,
                 (cmps[p] < S_VT) ? int'(IRQ_EN) : 0);
      end
    end
    line_cmp = 10'd1023;
  endtask

  task automatic test_polarity();
    obs_t got, exp;
    int h_low = 0, v_low = 0;
    reset = 1'b1; pix_ce = 1'b1; polarity = 1'b0;
    cycle_small();
    got = s_obs; exp = s_q.pop_front(); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL polarity_reset: got %h expected %h", got, exp);
    end
    reset = 1'b0;
    for (int c = 0; c < S_FRAME + 40; c++) begin
      if (c == S_FRAME) polarity = 1'b1;
      cycle_small();
      got = s_obs; exp = s_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL polarity c=%0d: got %h expected %h", c, got, exp);
      end
      if (c < S_FRAME) begin
        if (!got.hsync) h_low++;
        if (!got.vsync) v_low++;
      end
    end
    tests_run++;
    if (h_low != S_HS * S_VT || v_low != S_VS * S_HT) begin
      tests_failed++;
      $display("[TB] FAIL polarity_low_counts: got h=%0d v=%0d expected h=%0d v=%0d",
               h_low, v_low, S_HS * S_VT, S_VS * S_HT);
    end
  endtask

  task automatic test_reset_midframe();
    obs_t got, exp;
    reset = 1'b1; pix_ce = 1'b1; polarity = 1'b1;
    cycle_small();
    void'(s_q.pop_front());
    reset = 1'b0;
    for (int c = 0; c < S_FRAME + 2 * S_HT + 5; c++) begin
      cycle_small();
      got = s_obs; exp = s_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL midframe_run c=%0d: got %h expected %h", c, got, exp);
      end
    end
    reset = 1'b1; pix_ce = 1'b0;
    cycle_small();
    got = s_obs; exp = s_q.pop_front(); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset: got %h expected %h", got, exp);
    end
    tests_run++;
    if ({got.visible, got.pix_x, got.pix_y, got.frame_count} !== 29'd0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset_clear: got vis=%b x=%0d y=%0d fc=%0d expected all 0",
               got.visible, got.pix_x, got.pix_y, got.frame_count);
    end
    reset = 1'b0; pix_ce = 1'b1;
    cycle_small();
    got = s_obs; exp = s_q.pop_front(); tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL midframe_restart: got %h expected %h", got, exp);
    end
    tests_run++;
    if ({got.frame_start, got.line_start} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL midframe_restart_strobe: got %b expected 11",
               {got.frame_start, got.line_start});
    end
  endtask

  task automatic test_frame_wrap();
    obs_t got, exp;
    reset = 1'b1; pix_ce = 1'b1; polarity = 1'b1;
    cycle_small();
    void'(s_q.pop_front());
    reset = 1'b0;
    for (int c = 1; c <= 256 * S_FRAME + 1; c++) begin
      cycle_small();
      got = s_obs; exp = s_q.pop_front();
      if (exp.frame_start || got.frame_start) begin
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("[TB] FAIL frame_wrap c=%0d: got %h expected %h", c, got, exp);
        end
      end
    end
    tests_run++;
    if ({got.frame_start, got.frame_count} !== {1'b1, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL frame_count_wrap: got fs=%b fc=%0d expected fs=1 fc=0",
               got.frame_start, got.frame_count);
    end
  endtask

  task automatic test_xga_line();
    obs_t got, exp;
    int rise = -1, high = 0;
    reset = 1'b1; pix_ce = 1'b1; polarity = 1'b1; line_cmp = 10'd1023;
    for (int i = 0; i < 2; i++) begin
      cycle_xga();
      got = x_obs; exp = x_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL xga_reset: got %h expected %h", got, exp);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 1347; c++) begin
      cycle_xga();
      got = x_obs; exp = x_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL xga_line c=%0d: got %h expected %h", c, got, exp);
      end
      if (got.hsync) begin
        high++;
        if (rise < 0) rise = c;
      end
    end
    tests_run++;
    if (rise != 1049 || high != 136) begin
      tests_failed++;
      $display("[TB] FAIL xga_hsync: got rise=%0d width=%0d expected rise=1049 width=136", rise, high);
    end
  endtask

  initial begin
    reset = 1'b1;
    pix_ce = 1'b0;
    polarity = 1'b1;
    line_cmp = 10'd1023;
    s_last = reset_out(1'b1);
    x_last = reset_out(1'b1);
    test_reset();
    test_first_frame();
    test_pix_ce_gating();
    test_line_irq();
    test_polarity();
    test_reset_midframe();
    test_frame_wrap();
    test_xga_line();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that sits directly upstream of the sprite/background renderer in the TinyQV video peripheral. It produces registered hsync, vsync, visible and active-area pixel coordinates for a 1024x768 frame driven from the 64 MHz project clock. It also provides frame/line strobes, a wrapping frame counter and an optional programmable scan-line interrupt. The renderer consumes `pix_x`/`pix_y`/`visible` and edge-detects `vsync` for its staging-to-active copy.

## Interface
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch
- `H_SYNC`, 136, hsync width
- `H_BP`, 160, horizontal back porch (H_TOTAL = 1344)
- `V_ACTIVE`, 768, visible lines
- `V_FP`, 3, vertical front porch
- `V_SYNC`, 6, vsync width
- `V_BP`, 29, vertical back porch (V_TOTAL = 806)

Ports:
- `clk`  in  1  project clock
- `reset`  in  1  synchronous, active-high reset
- `pix_ce`  in  1  pixel advance enable; counters and outputs hold when low
- `polarity`  in  1  sync active level (1 = positive, 0 = negative)
- `line_cmp`  in  10  scan-line compare value for `line_irq`
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `visible`  out  1  active-area flag
- `pix_x`  out  10  active-area column
- `pix_y`  out  10  active-area row
- `frame_start`  out  1  one-cycle pulse at the first pixel of a frame
- `line_start`  out  1  one-cycle pulse at the first pixel of every line
- `frame_count`  out  8  completed-frame counter, wraps
- `line_irq`  out  1  one-cycle scan-line interrupt pulse

## Operation
- Internal `h_cnt` is 11 bits, 0..H_TOTAL-1. Internal `v_cnt` is 10 bits, 0..V_TOTAL-1.
- On a `pix_ce` cycle, `h_cnt` increments. At H_TOTAL-1 it wraps to 0 and `v_cnt` increments. At `v_cnt` = V_TOTAL-1 with `h_cnt` wrapping, both wrap to 0 and `frame_count` increments (mod 256).
- Decode is from the current counters and registered into the outputs:
  - `visible` = h<H_ACTIVE && v<V_ACTIVE
  - `hsync` = polarity when h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~polarity
  - `vsync` = polarity when v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else ~polarity
  - `pix_x` = h_cnt[9:0] when h<H_ACTIVE, else 0
  - `pix_y` = v_cnt when v<V_ACTIVE, else 0
  - `line_start` = (h==0); `frame_start` = (h==0 && v==0)
- `polarity` is sampled every cycle; a change takes effect on the next output update.
- When `pix_ce` is low, counters, frame_count and all outputs hold, except `frame_start`, `line_start` and `line_irq`, which are forced to 0.

## Timing
- Reset values: h_cnt=0, v_cnt=0, frame_count=0, visible=0, pix_x=0, pix_y=0, frame_start=0, line_start=0, line_irq=0, hsync=vsync=~polarity.
- Latency is one cycle: the outputs in cycle n+1 reflect the counter state in cycle n (with pix_ce=1).
- The first `pix_ce` cycle after reset release outputs the h=0,v=0 state: frame_start=1, line_start=1, visible=1.
- A frame is 1,083,264 `pix_ce` cycles; the line-end and frame-end wraps occur in the same cycle.
- `line_irq` pulses together with the h=H_ACTIVE output state when v_cnt==`line_cmp`. A `line_cmp` value ≥ V_TOTAL never fires. A `line_cmp` change takes effect at the next compare.
- Reset asserted mid-frame returns to the reset values on the next edge, regardless of `pix_ce`.

## Configuration
- `VGA_TIMING_LINE_IRQ_EN`:
  - Defined: the compare logic drives `line_irq` as above.
  - Undefined: `line_irq` is tied to 0, `line_cmp` is ignored (port retained), and no compare logic is built.

## Structure
- Shared package `vga_timing_pkg`: the default XGA timing constants, H_TOTAL/V_TOTAL localparams, and counter-width constants.
- One natural sub-module, `vga_axis_counter`, instantiated for H and for V:
  - parameterised active/fp/sync/bp
  - inputs: advance enable; outputs: wrap flag, active flag, sync-window flag and count.
- The top level registers the outputs, applies polarity, and owns frame_count and line_irq.

## Test plan
- Reset, then release with pix_ce=1 and polarity=1: cycle 1 gives frame_start=1, line_start=1, visible=1, pix_x=0, pix_y=0. hsync first rises 1048 cycles after that and stays high 136 cycles.
- Run one full frame: vsync is high for exactly 6×1344 cycles starting at line 771. The next frame_start arrives 1,083,264 cycles later and frame_count=1.
- Run 256 frames: frame_count wraps to 0, coincident with frame_start.
- pix_ce toggling 1/0: all outputs hold on 0-cycles, pulse outputs are low on 0-cycles, and the frame length measured in pix_ce=1 cycles is unchanged.
- With the macro defined, line_cmp=100: line_irq pulses once per frame, on the output where pix_y=100 and visible falls. line_cmp=900 produces no pulse. With the macro undefined, line_irq stays 0.
- Polarity=0 gives inverted hsync/vsync levels. Asserting reset at line 400 gives reset values on the next edge, then a restart from frame_start.
